// File: rtl/aes_key_sched_gen.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle into a word store with an indexed round-key read port.
// Latency start->done 42/48/54 cycles; start is ignored while busy or done, no backpressure on the read port.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset of entry a is 8*(255-a) = {~a, 3'b000}.
    assign s_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module aes_key_sched_gen #(
    parameter int MAX_NK     = 8,
    parameter int RD_LATENCY = 0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_err,
    output logic [3:0]   num_rounds,
    output logic         rd_valid,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

    state_t      state_q;
    // Power-of-two depth keeps every 6-bit index in range; words 60..63 are never written.
    logic [31:0] w_q [64];
    logic [3:0]  nk_q;
    logic [3:0]  nr_q;
    logic [5:0]  i_q;
    logic [2:0]  j_q;
    logic [7:0]  rcon_q;
    logic        busy_q;
    logic        done_q;
    logic        key_err_q;
    logic        rd_valid_q;
    logic [3:0]  num_rounds_q;

    logic [3:0]  req_nk;
    logic [3:0]  req_nr;
    logic        req_ok;

    always_comb begin
        req_nk = 4'd4;
        req_nr = 4'd10;
        case (key_len)
            2'b01:   begin req_nk = 4'd6; req_nr = 4'd12; end
            2'b10:   begin req_nk = 4'd8; req_nr = 4'd14; end
            default: begin req_nk = 4'd4; req_nr = 4'd10; end
        endcase
        req_ok = (key_len != 2'b11) && (int'(req_nk) <= MAX_NK);
    end

    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t_word;
    logic [31:0] w_new;
    logic [5:0]  last_idx;
    logic [7:0]  rcon_next;
    logic        j_first;
    logic        j_mid256;
    logic        j_last;

    assign w_prev    = w_q[i_q - 6'd1];
    assign w_back    = w_q[i_q - {2'b00, nk_q}];
    assign j_first   = (j_q == 3'd0);
    assign j_mid256  = (nk_q == 4'd8) && (j_q == 3'd4);
    assign j_last    = ({1'b0, j_q} == nk_q - 4'd1);
    assign sub_in    = j_first ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign last_idx  = {nr_q, 2'b00} + 6'd3;
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (sub_in[8*g +: 8]),
            .s_o (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        t_word = w_prev;
        if (j_first) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (j_mid256) begin
            t_word = sub_out;
        end
        w_new = w_back ^ t_word;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            for (int k = 0; k < 64; k++) begin
                w_q[k] <= '0;
            end
            nk_q         <= '0;
            nr_q         <= '0;
            i_q          <= '0;
            j_q          <= '0;
            rcon_q       <= 8'h01;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            key_err_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            num_rounds_q <= '0;
        end else begin
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            nk_q       <= req_nk;
                            nr_q       <= req_nr;
                            rd_valid_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_LOAD;
                        end else begin
                            key_err_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    for (int k = 0; k < 8; k++) begin
                        if (4'(k) < nk_q) begin
                            w_q[k] <= key_in[255 - 32*k -: 32];
                        end
                    end
                    i_q     <= {2'b00, nk_q};
                    j_q     <= 3'd0;
                    rcon_q  <= 8'h01;
                    state_q <= S_EXPAND;
                end
                S_EXPAND: begin
                    w_q[i_q] <= w_new;
                    if (j_first) begin
                        rcon_q <= rcon_next;
                    end
                    i_q <= i_q + 6'd1;
                    j_q <= j_last ? 3'd0 : j_q + 3'd1;
                    if (i_q == last_idx) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q       <= 1'b1;
                    rd_valid_q   <= 1'b1;
                    num_rounds_q <= nr_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [5:0]   rd_base;
    logic [127:0] rd_key_c;

    assign rd_base = {rd_round, 2'b00};

    always_comb begin
        rd_key_c = '0;
        if (rd_valid_q && (rd_round <= num_rounds_q)) begin
            rd_key_c = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end

    if (RD_LATENCY == 1) begin : g_rd_reg
        logic [127:0] rd_key_q;
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                rd_key_q <= '0;
            end else begin
                rd_key_q <= rd_key_c;
            end
        end
        assign rd_key = rd_key_q;
    end else begin : g_rd_comb
        assign rd_key = rd_key_c;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign key_err    = key_err_q;
    assign num_rounds = num_rounds_q;
    assign rd_valid   = rd_valid_q;
endmodule

// File: tb/tb_aes_key_sched_gen.sv
// Bench for aes_key_sched_gen: FIPS-197 key expansion model with an S-box derived from GF(2^8) inversion,
// directed AES-128/192/256 jobs, error starts, ignored starts, mid-job reset and a registered-read instance.
module tb_aes_key_sched_gen;
    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic         start4;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [3:0]   rd_round;

    logic         busy, done, key_err, rd_valid;
    logic [3:0]   num_rounds;
    logic [127:0] rd_key;
    logic         busy4, done4, key_err4, rd_valid4;
    logic [3:0]   num_rounds4;
    logic [127:0] rd_key4;

    aes_key_sched_gen #(.MAX_NK(8), .RD_LATENCY(0)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .key_err(key_err), .num_rounds(num_rounds),
        .rd_valid(rd_valid), .rd_round(rd_round), .rd_key(rd_key)
    );

    aes_key_sched_gen #(.MAX_NK(4), .RD_LATENCY(1)) u_dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .key_len(key_len), .key_in(key_in),
        .busy(busy4), .done(done4), .key_err(key_err4), .num_rounds(num_rounds4),
        .rd_valid(rd_valid4), .rd_round(rd_round), .rd_key(rd_key4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] T1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] T2_R12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [127:0] T3_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_t [256];
    logic [31:0] pend_w [60];
    logic [3:0]  pend_nr;
    logic [31:0] m_w [60];
    logic [3:0]  m_nr    = 4'd0;
    logic        m_valid = 1'b0;
    logic        chk_en  = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] p;
        p = 8'h01;
        for (int q = 1; q < n; q++) p = gmul(p, 8'h02);
        return p;
    endfunction

    task automatic expand_model(input logic [1:0] kl, input logic [255:0] k);
        int nk, nr;
        logic [31:0] temp;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        pend_nr = 4'(nr);
        for (int i = 0; i < 60; i++) pend_w[i] = 32'h0;
        for (int i = 0; i < nk; i++) pend_w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = pend_w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                temp = subw(temp);
            end
            pend_w[i] = pend_w[i-nk] ^ temp;
        end
    endtask

    function automatic logic [127:0] exp_key(input logic [3:0] r);
        int b;
        if (!m_valid || r > m_nr) return 128'h0;
        b = 4 * int'(r);
        return {m_w[b], m_w[b+1], m_w[b+2], m_w[b+3]};
    endfunction

    // Read-port compare on every cycle once checking is enabled
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("rd_valid", rd_valid, m_valid);
            chk("num_rounds", 128'(num_rounds), 128'(m_nr));
            chk("rd_key", rd_key, exp_key(rd_round));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_job(input logic [1:0] kl, input logic [255:0] k, input bit both,
                           input int e1, input int e2);
        int lat;
        lat = (kl == 2'b00) ? 42 : (kl == 2'b01) ? 48 : 54;
        expand_model(kl, k);
        @(negedge clk);
        key_len = kl; key_in = k; start = 1'b1; start4 = both;
        for (int c = 0; c <= lat + 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) m_valid = 1'b0;
            if (c == lat) begin
                m_w = pend_w; m_nr = pend_nr; m_valid = 1'b1;
            end
            rd_round = 4'(c);
            @(negedge clk);
            chk1("done", done, c == lat);
            chk1("busy", busy, c < lat - 1);
            chk1("key_err_job", key_err, 1'b0);
            if (both) begin
                chk1("done4", done4, c == lat);
                chk1("busy4", busy4, c < lat - 1);
            end
            start  = (c + 1 == e1) || (c + 1 == e2);
            start4 = 1'b0;
        end
    endtask

    task automatic err_job(input logic [1:0] kl, input bit on4, input string tag);
        @(negedge clk);
        key_len = kl;
        if (on4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start4 = 1'b0;
        chk1({tag, "_pulse"}, on4 ? key_err4 : key_err, 1'b1);
        chk1({tag, "_busy"}, on4 ? busy4 : busy, 1'b0);
        @(negedge clk);
        chk1({tag, "_end"}, on4 ? key_err4 : key_err, 1'b0);
        chk1({tag, "_valid"}, on4 ? rd_valid4 : rd_valid, 1'b1);
    endtask

    task automatic read_lit(input logic [3:0] r, input logic [127:0] lit, input string tag);
        @(posedge clk); #1;
        rd_round = r;
        #1;
        chk({tag, "_dut"}, rd_key, lit);
        chk({tag, "_model"}, exp_key(r), lit);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, key_err, 1'b0);
        chk({tag, "_nr"}, 128'(num_rounds), 128'h0);
        chk1({tag, "_valid"}, rd_valid, 1'b0);
        chk({tag, "_key"}, rd_key, 128'h0);
        chk1({tag, "_busy4"}, busy4, 1'b0);
        chk1({tag, "_done4"}, done4, 1'b0);
        chk1({tag, "_err4"}, key_err4, 1'b0);
        chk({tag, "_nr4"}, 128'(num_rounds4), 128'h0);
        chk1({tag, "_valid4"}, rd_valid4, 1'b0);
        chk({tag, "_key4"}, rd_key4, 128'h0);
    endtask

    initial begin
        n_rst = 1'b1; start = 1'b0; start4 = 1'b0;
        key_len = 2'b00; key_in = '0; rd_round = 4'd0;
        for (int i = 0; i < 60; i++) m_w[i] = 32'h0;
        build_sbox();
        chk("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        chk("sbox_53", 128'(sbox_t[8'h53]), 128'hed);

        #2 n_rst = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        chk_en = 1'b1;

        // T1, also on the MAX_NK=4 registered-read instance
        run_job(2'b00, KEY128, 1'b1, -1, -1);
        read_lit(4'd10, T1_R10, "t1_r10");
        chk("t1_nr", 128'(num_rounds), 128'd10);
        chk("t1_r0_model", exp_key(4'd0), KEY128[255:128]);
        @(posedge clk); #1 rd_round = 4'd3;
        @(posedge clk); #1 rd_round = 4'd10;
        #1 chk("rd4_hold", rd_key4, exp_key(4'd3));
        @(posedge clk); #1 chk("rd4_update", rd_key4, T1_R10);
        chk("nr4", 128'(num_rounds4), 128'd10);

        // T2 / T3
        run_job(2'b01, KEY192, 1'b0, -1, -1);
        read_lit(4'd12, T2_R12, "t2_r12");
        chk("t2_nr", 128'(num_rounds), 128'd12);
        run_job(2'b10, KEY256, 1'b0, -1, -1);
        read_lit(4'd14, T3_R14, "t3_r14");
        read_lit(4'd0, KEY256[255:128], "t3_r0");

        // T4: rejected key lengths keep the stored schedules
        err_job(2'b11, 1'b0, "err_rsv");
        err_job(2'b10, 1'b1, "err4_256");
        err_job(2'b01, 1'b1, "err4_192");
        read_lit(4'd14, T3_R14, "t4_keep");
        @(posedge clk); #1 chk("t4_keep4", rd_key4, exp_key(4'd14) == 128'h0 ? 128'h0 : rd_key4);
        chk("t4_keep4_r14", rd_key4, 128'h0);

        // T5: starts mid-job are ignored; out-of-range round reads zero
        run_job(2'b00, KEY128, 1'b0, 5, 20);
        read_lit(4'd10, T1_R10, "t5_r10");
        read_lit(4'd11, 128'h0, "t5_r11");

        // T6: reset in the middle of EXPAND, then repeat T1
        @(negedge clk);
        key_len = 2'b00; key_in = KEY128; start = 1'b1;
        @(posedge clk); #1 m_valid = 1'b0;
        @(negedge clk) start = 1'b0;
        repeat (20) @(posedge clk);
        #2 n_rst = 1'b0; m_nr = 4'd0; m_valid = 1'b0;
        #1 check_reset_outputs("t6_rst");
        repeat (2) @(negedge clk);
        chk1("t6_rst_done", done, 1'b0);
        @(posedge clk); #2 n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("t6_idle_busy", busy, 1'b0);
            chk1("t6_idle_done", done, 1'b0);
        end
        run_job(2'b00, KEY128, 1'b0, -1, -1);
        read_lit(4'd10, T1_R10, "t6_r10");

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
